// File: rtl/key_event_pkg.sv
// key_event_pkg -- shared definitions for the key_event block.
//   key_state_e   : per-channel press classifier state (IDLE, HELD, LONGED)
//   DEB_CYC_50M   : default debounce length, 20 ms at 50 MHz
//   LONG_CYC_50M  : default long-press threshold, 1 s at 50 MHz
package key_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_LONGED = 2'd2
  } key_state_e;

  localparam int unsigned DEB_CYC_50M  = 1_000_000;
  localparam int unsigned LONG_CYC_50M = 50_000_000;

endpackage

// File: rtl/key_chan.sv
// key_chan -- one key channel: 2-FF synchronizer, debounce, press classifier.
//   clk_i        : system clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   key_i        : raw asynchronous key, 1 = pressed
//   key_level_o  : debounced level, 1 = pressed
//   key_short_o  : one-cycle pulse, press released before the long threshold
//   key_long_o   : one-cycle pulse, long-press threshold reached
module key_chan
  import key_event_pkg::*;
#(
  parameter int unsigned DEB_CYC  = DEB_CYC_50M,
  parameter int unsigned LONG_CYC = LONG_CYC_50M
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic key_level_o,
  output logic key_short_o,
  output logic key_long_o
);

  localparam logic [31:0] DEB_LAST  = 32'(DEB_CYC - 1);
  localparam logic [31:0] LONG_LAST = 32'(LONG_CYC - 1);

  logic        sync1_q, sync2_q;
  logic [31:0] deb_cnt_q, deb_cnt_d;
  logic        level_q, level_d;
  logic        rise;

  key_state_e  state_q;
  logic [31:0] hold_q;
  logic        short_q, long_q;

  // Counter tracks how long sync2_q has disagreed with the accepted level.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    level_d   = level_q;
    if (sync2_q == level_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      level_d   = sync2_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + 32'd1;
    end
  end

  assign rise = level_d & ~level_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
    end else begin
      sync1_q   <= key_i;
      sync2_q   <= sync1_q;
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
    end
  end

  // IDLE->HELD is taken on the same edge the debounced level rises, so the
  // hold count equals the number of cycles key_level has been high.
  // Release is seen through level_q, so key_short lands one cycle after the
  // level falls and a fall coinciding with the threshold yields key_short.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      short_q <= 1'b0;
      long_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_q <= ST_HELD;
            hold_q  <= '0;
          end
        end
        ST_HELD: begin
          if (!level_q) begin
            state_q <= ST_IDLE;
            short_q <= 1'b1;
          end else if (hold_q == LONG_LAST) begin
            state_q <= ST_LONGED;
            long_q  <= 1'b1;
          end else begin
            hold_q <= hold_q + 32'd1;
          end
        end
        ST_LONGED: begin
          if (!level_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign key_level_o = level_q;
  assign key_short_o = short_q;
  assign key_long_o  = long_q;

endmodule

// File: rtl/key_event.sv
// key_event -- NKEY independent debounced keys with short/long press events.
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   key        : raw asynchronous key inputs, 1 = pressed
//   key_level  : debounced levels
//   key_short  : per-channel one-cycle short-press pulses
//   key_long   : per-channel one-cycle long-press pulses
module key_event
  import key_event_pkg::*;
#(
  parameter int unsigned NKEY     = 4,
  parameter int unsigned DEB_CYC  = DEB_CYC_50M,
  parameter int unsigned LONG_CYC = LONG_CYC_50M
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NKEY-1:0] key,
  output logic [NKEY-1:0] key_level,
  output logic [NKEY-1:0] key_short,
  output logic [NKEY-1:0] key_long
);

  for (genvar g = 0; g < NKEY; g++) begin : g_chan
    key_chan #(
      .DEB_CYC  (DEB_CYC),
      .LONG_CYC (LONG_CYC)
    ) u_chan (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .key_i       (key[g]),
      .key_level_o (key_level[g]),
      .key_short_o (key_short[g]),
      .key_long_o  (key_long[g])
    );
  end

endmodule

// File: tb/tb_key_event.sv
module tb_key_event;

  localparam int unsigned NK  = 4;
  localparam int unsigned DEB = 4;
  localparam int unsigned LNG = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key = '0;
  logic [NK-1:0] key_level, key_short, key_long;

  always #5 clk = ~clk;

  key_event #(
    .NKEY     (NK),
    .DEB_CYC  (DEB),
    .LONG_CYC (LNG)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .key_level (key_level),
    .key_short (key_short),
    .key_long  (key_long)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    int unsigned cyc;
    bit          is_long;
  } ev_t;

  // Expected events per channel, produced by the reference model.
  ev_t exp_q [NK][$];

  // Reference model state: edge index since reset release, raw key history,
  // debounced level and press bookkeeping.
  int unsigned n        = 0;
  bit          in_reset = 1'b1;
  logic [15:0] samp     [NK];
  bit          mlevel   [NK];
  bit          pending  [NK];
  int unsigned rise_at  [NK];

  // The synchronized view at edge m is the raw key sampled two edges earlier;
  // a level change needs DEB consecutive synchronized samples opposing it.
  function automatic bit window_is(logic [15:0] s, bit v);
    for (int k = 2; k <= int'(DEB) + 1; k++)
      if (s[k] != v) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    ev_t e;
    for (int c = 0; c < int'(NK); c++) begin
      samp[c] = '0; mlevel[c] = 1'b0; pending[c] = 1'b0; rise_at[c] = 0;
    end
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        in_reset = 1'b1;
        n = 0;
        for (int c = 0; c < int'(NK); c++) begin
          samp[c] = '0; mlevel[c] = 1'b0; pending[c] = 1'b0;
          exp_q[c].delete();
        end
      end else begin
        in_reset = 1'b0;
        n++;
        for (int c = 0; c < int'(NK); c++) begin
          bit prev;
          prev = mlevel[c];
          samp[c] = {samp[c][14:0], key[c]};
          // Level held high for LNG cycles: long event at that edge.
          if (pending[c] && n == rise_at[c] + LNG) begin
            e.cyc = n; e.is_long = 1'b1;
            exp_q[c].push_back(e);
            pending[c] = 1'b0;
          end
          if (window_is(samp[c], !prev)) mlevel[c] = !prev;
          if (!prev && mlevel[c]) begin
            rise_at[c] = n;
            pending[c] = 1'b1;
          end
          if (prev && !mlevel[c] && pending[c]) begin
            e.cyc = n + 1; e.is_long = 1'b0;
            exp_q[c].push_back(e);
            pending[c] = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (in_reset) begin
        total++;
        if (key_level !== '0 || key_short !== '0 || key_long !== '0) begin
          bad++;
          $display("FAIL reset_outputs: level=%b short=%b long=%b, required all 0",
                   key_level, key_short, key_long);
        end
      end else begin
        for (int c = 0; c < int'(NK); c++) begin
          total++;
          if (key_level[c] !== mlevel[c]) begin
            bad++;
            $display("FAIL level ch%0d cyc%0d: got %b, required %b", c, n, key_level[c], mlevel[c]);
          end
          if (key_short[c] === 1'b1 && key_long[c] === 1'b1) begin
            total++; bad++;
            $display("FAIL both_pulses ch%0d cyc%0d: short=1 long=1, required at most one", c, n);
          end
          if (key_short[c] === 1'b1 || key_long[c] === 1'b1) begin
            total++;
            if (exp_q[c].size() == 0) begin
              bad++;
              $display("FAIL unexpected_event ch%0d cyc%0d: short=%b long=%b, required none",
                       c, n, key_short[c], key_long[c]);
            end else begin
              e = exp_q[c].pop_front();
              if (e.cyc != n || e.is_long != key_long[c]) begin
                bad++;
                $display("FAIL event ch%0d: got %s at cyc%0d, required %s at cyc%0d", c,
                         key_long[c] ? "long" : "short", n, e.is_long ? "long" : "short", e.cyc);
              end
            end
          end else if (exp_q[c].size() != 0 && exp_q[c][0].cyc <= n) begin
            total++; bad++;
            e = exp_q[c].pop_front();
            $display("FAIL missing_event ch%0d: got none at cyc%0d, required %s at cyc%0d",
                     c, n, e.is_long ? "long" : "short", e.cyc);
          end
        end
      end
    end
  end

  task automatic tick(input int unsigned k);
    repeat (k) @(negedge clk);
    #1;
  endtask

  task automatic hold_keys(input logic [NK-1:0] mask, input int unsigned hi, input int unsigned lo);
    key = mask;
    tick(hi);
    key = '0;
    tick(lo);
  endtask

  initial begin
    int unsigned run [NK];
    rst_n = 1'b0;
    key   = '0;
    tick(3);
    rst_n = 1'b1;
    tick(5);

    hold_keys(4'b0001, 10, 20);        // short press on key 0
    hold_keys(4'b0010, 40, 20);        // long press on key 1
    repeat (6) hold_keys(4'b0100, 3, 3); // glitches on key 2
    tick(15);
    hold_keys(4'b1001, 10, 20);        // simultaneous shorts on keys 0 and 3
    hold_keys(4'b0001, 19, 30);        // level falls with hold count at threshold-1
    hold_keys(4'b0001, 20, 30);        // one cycle longer: long press

    // Reset in the middle of a held press, key kept high through release.
    key = 4'b0010;
    tick(10);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(40);
    key = '0;
    tick(20);

    // Random run lengths, biased so some presses straddle the long threshold.
    for (int c = 0; c < int'(NK); c++) run[c] = $urandom_range(1, 30);
    for (int t = 0; t < 2000; t++) begin
      for (int c = 0; c < int'(NK); c++) begin
        if (run[c] == 0) begin
          key[c] = ~key[c];
          if ($urandom_range(0, 3) == 0) run[c] = $urandom_range(18, 26);
          else                           run[c] = $urandom_range(1, 30);
        end
        run[c]--;
      end
      tick(1);
    end
    key = '0;
    tick(40);

    for (int c = 0; c < int'(NK); c++) begin
      total++;
      if (exp_q[c].size() != 0) begin
        bad++;
        $display("FAIL leftover_events ch%0d: got %0d pending, required 0", c, exp_q[c].size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
